// File: rtl/hex_scan_if.sv
// Load handshake between the register-view path and the hex scan controller.
// The master offers display words and the slave accepts them into its pending slot.
interface hex_scan_if #(
    parameter int NUM_DIGITS = 8
) ();
    logic                    load_valid;
    logic [4*NUM_DIGITS-1:0] load_data;
    logic                    load_ready;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );
endinterface

// File: rtl/hex_scan_ctrl.sv
// Multiplexed common-anode seven-segment scanner with frame-aligned word commit.
// Optional HEX_SCAN_GHOST_BLANK_EN darkens the anodes for 2 cycles at slot start.
module hex_scan_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 50000,
    parameter int DIV_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    hex_scan_if.slave             ld,
    input  logic                  blank_lz,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic [6:0]            segs
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int W     = 4 * NUM_DIGITS;
    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic [DIV_W-1:0] cnt, cnt_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [W-1:0]     pending, shown, shown_nxt;
    logic             pending_full, pf_nxt;
    logic             shown_valid, sv_nxt;
    logic             tick, wrap, commit, accept;
    logic             zf;
    logic [NUM_DIGITS-1:0] zero_from;
    logic [3:0]       nib;
    logic [6:0]       segs_nxt;
    logic [NUM_DIGITS-1:0] sel_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        tick    = (cnt == DIV_W'(REFRESH_DIV - 1));
        wrap    = tick && (idx == IDX_W'(NUM_DIGITS - 1));
        commit  = wrap && pending_full;
        accept  = ld.load_valid && ld.load_ready;
        cnt_nxt = tick ? '0 : cnt + 1'b1;
        if (wrap)
            idx_nxt = '0;
        else if (tick)
            idx_nxt = idx + 1'b1;
        else
            idx_nxt = idx;
        shown_nxt = commit ? pending : shown;
        sv_nxt    = shown_valid | commit;
        if (commit)
            pf_nxt = 1'b0;
        else if (accept)
            pf_nxt = 1'b1;
        else
            pf_nxt = pending_full;
    end

    // zero_from[k]: nibbles k..top of the word about to be shown are all zero
    always_comb begin
        zf        = 1'b1;
        zero_from = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zf           = zf & (shown_nxt[4*k +: 4] == 4'h0);
            zero_from[k] = zf;
        end
    end

    always_comb begin
        nib = shown_nxt[{idx_nxt, 2'b00} +: 4];
        if (!sv_nxt)
            segs_nxt = DASH;
        else if (blank_lz && idx_nxt != '0 && zero_from[idx_nxt])
            segs_nxt = BLANK;
        else
            segs_nxt = hex7(nib);
        sel_nxt = ~(NUM_DIGITS'(1) << idx_nxt);
`ifdef HEX_SCAN_GHOST_BLANK_EN
        if (cnt_nxt < DIV_W'(2))
            sel_nxt = '1;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt           <= '0;
            idx           <= '0;
            pending       <= '0;
            pending_full  <= 1'b0;
            shown         <= '0;
            shown_valid   <= 1'b0;
            ld.load_ready <= 1'b1;
            segs          <= DASH;
`ifdef HEX_SCAN_GHOST_BLANK_EN
            digit_sel     <= '1;
`else
            digit_sel     <= ~(NUM_DIGITS'(1));
`endif
        end else begin
            cnt           <= cnt_nxt;
            idx           <= idx_nxt;
            if (accept)
                pending   <= ld.load_data;
            pending_full  <= pf_nxt;
            shown         <= shown_nxt;
            shown_valid   <= sv_nxt;
            ld.load_ready <= ~pf_nxt;
            segs          <= segs_nxt;
            digit_sel     <= sel_nxt;
        end
    end
endmodule

// File: doc/hex_scan_ctrl.md
Name: hex_scan_ctrl

Overview:
- Time-multiplexed controller for a bank of common-anode seven-segment digits.
- Shares a single hex-to-segment decode across NUM_DIGITS digit positions by scanning one digit per refresh slot.
- Accepts new display words through a valid/ready handshake and commits them only at frame boundaries, so a frame never mixes old and new digits.
- Sits between the CPU's debug/register-view path and the board's segment and anode pins.

Parameters:
- NUM_DIGITS, 8: number of scanned digit positions; allowed range 2..8.
- REFRESH_DIV, 50000: clock cycles each digit is driven; minimum 2.
- DIV_W, 16: width of the refresh counter; must satisfy 2^DIV_W >= REFRESH_DIV.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- load_valid  in  1  new display word offered.
- load_data  in  4*NUM_DIGITS  nibble k drives digit k; digit 0 is the least significant.
- load_ready  out  1  pending slot empty; a word is accepted when load_valid and load_ready are both high at a clock edge.
- blank_lz  in  1  when 1, suppress leading zeros.
- digit_sel  out  NUM_DIGITS  active-low anode enables; at most one bit low at any time.
- segs  out  7  active-low segments {g,f,e,d,c,b,a}.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset; all state is updated only on the rising edge of clk.
- Reset values:
  - refresh counter cnt = 0; digit index idx = 0.
  - pending_full = 0, so load_ready = 1.
  - shown_valid = 0.
  - digit_sel = all ones except bit 0 low.
  - segs = 7'b0111111 (dash).
- Refresh:
  - cnt counts 0..REFRESH_DIV-1 and wraps.
  - tick is asserted when cnt == REFRESH_DIV-1.
  - On a tick edge, idx advances by 1 and wraps from NUM_DIGITS-1 to 0.
- Outputs:
  - digit_sel and segs are registered and are loaded from the next-state idx.
  - They therefore change on the same edge as idx, and each digit is driven for exactly REFRESH_DIV cycles.
- Handshake:
  - load_ready is registered and equals ~pending_full.
  - On accept, load_data is copied into the pending register and pending_full is set.
  - load_data is ignored whenever load_ready = 0.
- Commit:
  - A commit happens on the tick edge where idx wraps NUM_DIGITS-1 -> 0 while pending_full = 1.
  - On commit: pending is copied to the shown register, shown_valid is set to 1, and pending_full is cleared.
  - load_ready returns to 1 on the cycle after the commit edge.
  - Digit 0 of the new frame already shows the new data.
- Simultaneous events: an accept and a commit cannot occur on the same edge, because load_ready = 0 whenever pending_full = 1. No priority rule is needed.
- Decode (active-low) for 0..F: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- Display before first commit: while shown_valid = 0, every digit shows the dash 0111111.
- Leading-zero blanking:
  - Applies when blank_lz = 1 and shown_valid = 1.
  - Digit k is blank (1111111) if nibbles k..NUM_DIGITS-1 are all zero and k != 0.
  - Digit 0 is always shown, so a value of 0 displays "0".
  - blank_lz is sampled every cycle and is not captured at commit.
- Reset mid-operation: pending data and shown data are discarded, and all state returns to the reset values on the next edge.

Optional Feature:
- Macro: HEX_SCAN_GHOST_BLANK_EN.
- When defined:
  - For the first 2 cycles of every digit slot, digit_sel is all ones while segs already holds the new pattern.
  - The slot's anode is then enabled for the remaining REFRESH_DIV-2 cycles.
  - This suppresses ghosting on slow anode drivers.
  - Requires REFRESH_DIV >= 3.
  - Applies after reset too: slot 0 is dark for its first 2 cycles.
- When undefined:
  - digit_sel switches directly from one digit to the next with no dark cycles.
  - No extra logic is instantiated.

Test Plan:
- Scan timing (NUM_DIGITS=4, REFRESH_DIV=4): hold reset 2 cycles, then release and idle.
  - digit_sel sequence is 1110 (4 cycles), 1101, 1011, 0111, 1110, ...
  - segs = 0111111 throughout; load_ready = 1.
- Accept and commit: assert load_valid with load_data=16'h1A3F during slot 1.
  - load_ready falls on the next cycle.
  - Slots 1..3 still show dashes.
  - From the wrap, digits 0..3 show F=0001110, 3=0110000, A=0001000, 1=1111001.
  - load_ready = 1 one cycle after the wrap.
- Backpressure: offer 16'h0001, then offer 16'h2222 while load_ready = 0.
  - The second word is not captured; the next frame shows 0001.
  - 2222 is accepted only after load_ready returns to 1 and load_valid is still held, and appears one frame later.
- Leading-zero blanking: shown 16'h0040 with blank_lz=1.
  - Digits 3 and 2 show 1111111; digit 1 shows 0011001; digit 0 shows 1000000.
  - With blank_lz=1 and shown 16'h0000: digit 0 = 1000000, others blank.
- Reset mid-frame: pulse reset during slot 2 with a pending word held.
  - On the next edge, digit_sel = 1110, segs = 0111111, load_ready = 1.
  - The pending word is never displayed.
- With HEX_SCAN_GHOST_BLANK_EN defined (REFRESH_DIV=4):
  - Each slot shows digit_sel = 1111 for 2 cycles, then the one-hot-low enable for 2 cycles.
  - segs changes at the start of the dark period.
